// File: rtl/instruction_fetch_unit.sv
// Pipeline front end: drives the ROM address from the PC, registers the returned instruction,
// resolves JMP locally and takes BLE redirects from execute.
module instruction_fetch_unit #(
    parameter int unsigned           ADDR_WIDTH = 16,
    parameter int unsigned           INSN_WIDTH = 28,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter logic [3:0]            JMP_OPCODE = 4'hA
) (
    input  logic                  Clock,
    input  logic                  Reset,
    output logic [ADDR_WIDTH-1:0] oAddress,
    input  logic [INSN_WIDTH-1:0] iInstruction,
    input  logic                  iStall,
    input  logic                  iBranchTaken,
    input  logic [7:0]            iBranchTarget,
    output logic [INSN_WIDTH-1:0] oInstruction,
    output logic [ADDR_WIDTH-1:0] oPC,
    output logic                  oValid
);

    typedef enum logic [1:0] {StStart, StRun, StRedirect} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] opc_q, opc_d;
    logic [INSN_WIDTH-1:0] insn_q, insn_d;
    logic                  valid_q, valid_d;

    logic                  is_jmp;
    logic [7:0]            jmp_target;

    assign is_jmp     = (iInstruction[INSN_WIDTH-1 -: 4] == JMP_OPCODE);
    assign jmp_target = iInstruction[INSN_WIDTH-5 -: 8];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        opc_d   = opc_q;
        insn_d  = insn_q;
        valid_d = valid_q;
        if (iBranchTaken) begin
            // Execute redirect outranks stall and any JMP currently on the ROM bus.
            pc_d    = ADDR_WIDTH'(iBranchTarget);
            insn_d  = '0;
            valid_d = 1'b0;
            state_d = StRedirect;
        end else if (iStall) begin
            state_d = state_q;
        end else if (is_jmp) begin
            // JMP is consumed here and never reaches decode.
            pc_d    = ADDR_WIDTH'(jmp_target);
            insn_d  = '0;
            valid_d = 1'b0;
            state_d = StRedirect;
        end else begin
            insn_d  = iInstruction;
            opc_d   = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + ADDR_WIDTH'(1);
            state_d = StRun;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= StStart;
            pc_q    <= RESET_PC;
            opc_q   <= '0;
            insn_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            opc_q   <= opc_d;
            insn_q  <= insn_d;
            valid_q <= valid_d;
        end
    end

    assign oAddress     = pc_q;
    assign oInstruction = insn_q;
    assign oPC          = opc_q;
    assign oValid       = valid_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: per-cycle stimulus and expected outputs are
// queued together, then popped and compared one clock edge at a time.
module tb_instruction_fetch_unit;

    localparam logic [3:0] JMP = 4'hA;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        rst_hi_n = 1'b0;
    logic        iStall = 1'b0;
    logic        iBranchTaken = 1'b0;
    logic [7:0]  iBranchTarget = 8'd0;
    logic [15:0] oAddress, hi_addr, hi_pc, oPC;
    logic [27:0] iInstruction, hi_rom, oInstruction, hi_insn;
    logic        oValid, hi_valid;

    int checks = 0;
    int passed = 0;

    typedef struct {
        logic        st;
        logic        br;
        logic [7:0]  tgt;
        logic        v;
        logic [15:0] pc;
        logic [27:0] insn;
        logic [15:0] addr;
    } step_t;

    step_t sb[$];

    always #5 Clock = ~Clock;

    // ROM image: 2 = STO R3, 4 = unknown opcode, 6 = BLE, 8 = ADD R1,R1,R3, 14 = JMP 2.
    function automatic logic [27:0] rom(input logic [15:0] a);
        case (a)
            16'd2:   return {4'h3, 8'd3, 8'd0, 8'd0};
            16'd4:   return {4'hF, 8'hDE, 8'hAD, 8'h04};
            16'd6:   return {4'hB, 8'd1, 8'd2, 8'd3};
            16'd8:   return {4'h1, 8'd1, 8'd1, 8'd3};
            16'd14:  return {JMP, 8'd2, 16'd0};
            default: return {4'h2, a[7:0], 8'h55, a[15:8]};
        endcase
    endfunction

    assign iInstruction = rom(oAddress);
    assign hi_rom       = rom(hi_addr);

    instruction_fetch_unit #(
        .ADDR_WIDTH(16), .INSN_WIDTH(28), .RESET_PC(16'd0), .JMP_OPCODE(JMP)
    ) dut (
        .Clock(Clock), .Reset(Reset), .oAddress(oAddress), .iInstruction(iInstruction),
        .iStall(iStall), .iBranchTaken(iBranchTaken), .iBranchTarget(iBranchTarget),
        .oInstruction(oInstruction), .oPC(oPC), .oValid(oValid)
    );

    instruction_fetch_unit #(
        .ADDR_WIDTH(16), .INSN_WIDTH(28), .RESET_PC(16'hFFFF), .JMP_OPCODE(JMP)
    ) dut_hi (
        .Clock(Clock), .Reset(rst_hi_n), .oAddress(hi_addr), .iInstruction(hi_rom),
        .iStall(1'b0), .iBranchTaken(1'b0), .iBranchTarget(8'd0),
        .oInstruction(hi_insn), .oPC(hi_pc), .oValid(hi_valid)
    );

    function automatic void push(input logic st, input logic br, input logic [7:0] tgt,
                                 input logic v, input logic [15:0] pc, input logic [27:0] insn,
                                 input logic [15:0] addr);
        step_t e;
        e.st = st; e.br = br; e.tgt = tgt; e.v = v; e.pc = pc; e.insn = insn; e.addr = addr;
        sb.push_back(e);
    endfunction

    task automatic do_reset();
        @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        Reset = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (oValid !== 1'b0 || oPC !== 16'd0 || oInstruction !== 28'd0 || oAddress !== 16'd0)
            $display("FAIL reset: got v=%0b pc=%h insn=%h addr=%h, want v=0 pc=0 insn=0 addr=0",
                     oValid, oPC, oInstruction, oAddress);
        else passed++;
        @(negedge Clock);
        Reset = 1'b1;
    endtask

    // Straight-line fetch 0..13, JMP at 14 back to 2, then run on to PC=10.
    task automatic test_fetch_jmp();
        step_t e;
        for (int n = 0; n < 14; n++) push(0, 0, 0, 1, 16'(n), rom(16'(n)), 16'(n + 1));
        push(0, 0, 0, 0, 0, 0, 16'd2);
        for (int n = 2; n < 10; n++) push(0, 0, 0, 1, 16'(n), rom(16'(n)), 16'(n + 1));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            iStall = e.st; iBranchTaken = e.br; iBranchTarget = e.tgt;
            @(posedge Clock); #1;
            checks++;
            if (oValid !== e.v || oAddress !== e.addr ||
                (e.v ? (oPC !== e.pc || oInstruction !== e.insn) : (oInstruction !== 28'd0)))
                $display("FAIL fetch_jmp: got v=%0b pc=%h insn=%h addr=%h, want v=%0b pc=%h insn=%h addr=%h",
                         oValid, oPC, oInstruction, oAddress, e.v, e.pc, e.insn, e.addr);
            else passed++;
        end
    endtask

    task automatic test_branch();
        step_t e;
        push(0, 1, 8'd8, 0, 0, 0, 16'd8);
        for (int n = 8; n < 11; n++) push(0, 0, 0, 1, 16'(n), rom(16'(n)), 16'(n + 1));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            iStall = e.st; iBranchTaken = e.br; iBranchTarget = e.tgt;
            @(posedge Clock); #1;
            checks++;
            if (oValid !== e.v || oAddress !== e.addr ||
                (e.v ? (oPC !== e.pc || oInstruction !== e.insn) : (oInstruction !== 28'd0)))
                $display("FAIL branch: got v=%0b pc=%h insn=%h addr=%h, want v=%0b pc=%h insn=%h addr=%h",
                         oValid, oPC, oInstruction, oAddress, e.v, e.pc, e.insn, e.addr);
            else passed++;
        end
        iBranchTaken = 1'b0;
    endtask

    // Stall at oPC=5, then stall+branch together, then stall held through the bubble.
    task automatic test_stall();
        step_t e;
        do_reset();
        for (int n = 0; n < 6; n++) push(0, 0, 0, 1, 16'(n), rom(16'(n)), 16'(n + 1));
        for (int n = 0; n < 3; n++) push(1, 0, 0, 1, 16'd5, rom(16'd5), 16'd6);
        for (int n = 6; n < 8; n++) push(0, 0, 0, 1, 16'(n), rom(16'(n)), 16'(n + 1));
        push(1, 1, 8'd5, 0, 0, 0, 16'd5);
        push(1, 0, 0, 0, 0, 0, 16'd5);
        push(1, 0, 0, 0, 0, 0, 16'd5);
        push(0, 0, 0, 1, 16'd5, rom(16'd5), 16'd6);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            iStall = e.st; iBranchTaken = e.br; iBranchTarget = e.tgt;
            @(posedge Clock); #1;
            checks++;
            if (oValid !== e.v || oAddress !== e.addr ||
                (e.v ? (oPC !== e.pc || oInstruction !== e.insn) : (oInstruction !== 28'd0)))
                $display("FAIL stall: got v=%0b pc=%h insn=%h addr=%h, want v=%0b pc=%h insn=%h addr=%h",
                         oValid, oPC, oInstruction, oAddress, e.v, e.pc, e.insn, e.addr);
            else passed++;
        end
        iStall = 1'b0; iBranchTaken = 1'b0;
    endtask

    task automatic test_wrap();
        logic [15:0] exp_pc;
        exp_pc = 16'hFFFF;
        @(negedge Clock);
        rst_hi_n = 1'b1;
        for (int n = 0; n < 2; n++) begin
            @(posedge Clock); #1;
            checks++;
            if (hi_valid !== 1'b1 || hi_pc !== exp_pc || hi_insn !== rom(exp_pc) ||
                hi_addr !== exp_pc + 16'd1)
                $display("FAIL wrap: got v=%0b pc=%h insn=%h addr=%h, want v=1 pc=%h insn=%h addr=%h",
                         hi_valid, hi_pc, hi_insn, hi_addr, exp_pc, rom(exp_pc), exp_pc + 16'd1);
            else passed++;
            exp_pc = exp_pc + 16'd1;
        end
    endtask

    task automatic test_async_reset();
        @(posedge Clock); #3;
        Reset = 1'b0;
        #1;
        checks++;
        if (oValid !== 1'b0 || oPC !== 16'd0 || oInstruction !== 28'd0 || oAddress !== 16'd0)
            $display("FAIL async_reset: got v=%0b pc=%h insn=%h addr=%h, want v=0 pc=0 insn=0 addr=0",
                     oValid, oPC, oInstruction, oAddress);
        else passed++;
        @(negedge Clock);
        Reset = 1'b1;
        @(posedge Clock); #1;
        checks++;
        if (oValid !== 1'b1 || oPC !== 16'd0 || oInstruction !== rom(16'd0) || oAddress !== 16'd1)
            $display("FAIL restart: got v=%0b pc=%h insn=%h addr=%h, want v=1 pc=0 insn=%h addr=1",
                     oValid, oPC, oInstruction, oAddress, rom(16'd0));
        else passed++;
    endtask

    initial begin
        test_reset();
        test_fetch_jmp();
        test_branch();
        test_stall();
        test_wrap();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

endmodule
